instr_mem_loader: RTL and testbench



---
 rtl/instr_mem_loader.sv | 120 ++++++++++++
 tb/tb_instr_mem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Loadable NUM_INS x WORD_SIZE instruction store: valid/ready load stream that
// fills the program from address 0, and a registered, range-checked fetch port.
module instr_mem_loader #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned NUM_INS    = 16,
    parameter int unsigned INDEX_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [WORD_SIZE-1:0]  load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  prog_loaded,
    output logic [INDEX_SIZE:0]   load_count,
    input  logic                  fetch_req,
    input  logic [INDEX_SIZE-1:0] prog_count,
    output logic [WORD_SIZE-1:0]  ins_val,
    output logic                  ins_valid,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_e;

    localparam logic [INDEX_SIZE-1:0] LAST_ADDR = INDEX_SIZE'(NUM_INS - 1);
    localparam logic [INDEX_SIZE:0]   DEPTH     = (INDEX_SIZE+1)'(NUM_INS);
    localparam logic [INDEX_SIZE-1:0] WPTR_INC  = INDEX_SIZE'(1);
    localparam logic [INDEX_SIZE:0]   CNT_INC   = (INDEX_SIZE+1)'(1);

    state_e                  state_q, state_d;
    logic [INDEX_SIZE-1:0]   wptr_q, wptr_d;
    logic [INDEX_SIZE:0]     cnt_q, cnt_d;
    logic                    wr_en;
    logic [WORD_SIZE-1:0]    mem_q [NUM_INS];
    logic                    load_ready_q, prog_loaded_q;
    logic [WORD_SIZE-1:0]    ins_val_q;
    logic                    ins_valid_q, fetch_err_q;
    logic                    addr_ok;

    // One extra bit so the range check stays meaningful when NUM_INS == 2^INDEX_SIZE.
    assign addr_ok = {1'b0, prog_count} < DEPTH;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            EMPTY, READY: begin
                if (load_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wptr_d = '0;
                    cnt_d  = '0;
                end else if (load_valid) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + WPTR_INC;
                    cnt_d  = cnt_q + CNT_INC;
                    if (load_last || (wptr_q == LAST_ADDR)) begin
                        state_d = READY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            wptr_q        <= '0;
            cnt_q         <= '0;
            load_ready_q  <= 1'b0;
            prog_loaded_q <= 1'b0;
            ins_val_q     <= '0;
            ins_valid_q   <= 1'b0;
            fetch_err_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_INS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            cnt_q         <= cnt_d;
            load_ready_q  <= (state_d == LOAD);
            prog_loaded_q <= (state_d == READY);
            if (wr_en) begin
                mem_q[wptr_q] <= load_data;
            end
            // Fetch is blocked while loading, so reads never collide with writes.
            if (fetch_req && (state_q != LOAD)) begin
                ins_valid_q <= 1'b1;
                if (addr_ok) begin
                    ins_val_q   <= mem_q[prog_count];
                    fetch_err_q <= 1'b0;
                end else begin
                    ins_val_q   <= '0;
                    fetch_err_q <= 1'b1;
                end
            end else begin
                ins_valid_q <= 1'b0;
                fetch_err_q <= 1'b0;
            end
        end
    end

    assign load_ready  = load_ready_q;
    assign prog_loaded = prog_loaded_q;
    assign load_count  = cnt_q;
    assign ins_val     = ins_val_q;
    assign ins_valid   = ins_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 16-word and a 12-word instance share stimulus
// and are compared every cycle against a program-level model plus literal checks.
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start, load_valid, load_last, fetch_req;
    logic [7:0] load_data;
    logic [3:0] prog_count;

    logic       rdy16, ld16, vld16, err16;
    logic [4:0] cnt16;
    logic [7:0] val16;
    logic       rdy12, ld12, vld12, err12;
    logic [4:0] cnt12;
    logic [7:0] val12;

    instr_mem_loader #(.WORD_SIZE(8), .NUM_INS(16), .INDEX_SIZE(4)) u16 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(rdy16),
        .prog_loaded(ld16), .load_count(cnt16), .fetch_req(fetch_req),
        .prog_count(prog_count), .ins_val(val16), .ins_valid(vld16), .fetch_err(err16)
    );

    instr_mem_loader #(.WORD_SIZE(8), .NUM_INS(12), .INDEX_SIZE(4)) u12 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(rdy12),
        .prog_loaded(ld12), .load_count(cnt12), .fetch_req(fetch_req),
        .prog_count(prog_count), .ins_val(val12), .ins_valid(vld12), .fetch_err(err12)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-level model: index 0 is the 16-word instance, index 1 the 12-word one.
    logic [7:0]  m_mem [2][16];
    bit          m_loading [2];
    bit          m_done [2];
    int unsigned m_cnt [2];
    logic [7:0]  e_val [2];
    bit          e_vld [2];
    bit          e_err [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            int unsigned n;
            n = (k == 0) ? 16 : 12;
            if (!rst_n) begin
                m_loading[k] = 0;
                m_done[k]    = 0;
                m_cnt[k]     = 0;
                e_val[k]     = 8'h00;
                e_vld[k]     = 0;
                e_err[k]     = 0;
                for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
            end else begin
                if (!m_loading[k] && fetch_req) begin
                    e_vld[k] = 1;
                    if (prog_count >= n) begin
                        e_val[k] = 8'h00;
                        e_err[k] = 1;
                    end else begin
                        e_val[k] = m_mem[k][prog_count];
                        e_err[k] = 0;
                    end
                end else begin
                    e_vld[k] = 0;
                    e_err[k] = 0;
                end
                if (load_start) begin
                    m_loading[k] = 1;
                    m_done[k]    = 0;
                    m_cnt[k]     = 0;
                end else if (m_loading[k] && load_valid) begin
                    m_mem[k][m_cnt[k]] = load_data;
                    m_cnt[k]++;
                    if (load_last || m_cnt[k] == n) begin
                        m_loading[k] = 0;
                        m_done[k]    = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("u16.load_ready",  rdy16, m_loading[0]);
        chk("u16.prog_loaded", ld16,  m_done[0]);
        chk("u16.load_count",  cnt16, m_cnt[0]);
        chk("u16.ins_valid",   vld16, e_vld[0]);
        chk("u16.fetch_err",   err16, e_err[0]);
        chk("u16.ins_val",     val16, e_val[0]);
        chk("u12.load_ready",  rdy12, m_loading[1]);
        chk("u12.prog_loaded", ld12,  m_done[1]);
        chk("u12.load_count",  cnt12, m_cnt[1]);
        chk("u12.ins_valid",   vld12, e_vld[1]);
        chk("u12.fetch_err",   err12, e_err[1]);
        chk("u12.ins_val",     val12, e_val[1]);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [3:0] pc);
        fetch_req  = 1'b1;
        prog_count = pc;
        cyc();
        fetch_req  = 1'b0;
    endtask

    logic [7:0] exp_t2 [4] = '{8'h11, 8'h22, 8'h33, 8'h00};

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        load_last = 1'b0; fetch_req = 1'b0; prog_count = 4'd0;
        repeat (3) cyc();
        chk("rst.load_ready", rdy16, 0);
        chk("rst.load_count", cnt16, 0);
        chk("rst.ins_valid",  vld16, 0);
        rst_n = 1'b1;
        cyc();

        // Empty memory fetch returns NOP
        fetch(4'd3);
        chk("t1.ins_valid",   vld16, 1);
        chk("t1.ins_val",     val16, 8'h00);
        chk("t1.fetch_err",   err16, 0);
        chk("t1.prog_loaded", ld16,  0);

        // Short program with load_last, then back-to-back fetches
        load_start = 1'b1; cyc(); load_start = 1'b0;
        chk("t2.load_ready", rdy16, 1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
        chk("t2.prog_loaded", ld16,  1);
        chk("t2.load_count",  cnt16, 3);
        chk("t2.load_ready",  rdy16, 0);
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            prog_count = 4'(i);
            cyc();
            chk("t2.ins_val",   val16, exp_t2[i]);
            chk("t2.ins_valid", vld16, 1);
        end
        fetch_req = 1'b0;
        cyc();
        chk("t2.idle_valid", vld16, 0);

        // Full program without load_last auto-terminates
        load_start = 1'b1; cyc(); load_start = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 1'b0);
        chk("t3.load_count",  cnt16, 16);
        chk("t3.prog_loaded", ld16,  1);
        chk("t3.load_ready",  rdy16, 0);
        chk("t3.u12_count",   cnt12, 12);
        fetch(4'd15);
        chk("t3.ins_val",     val16, 8'hAF);
        chk("t3.u12_err",     err12, 1);
        chk("t3.u12_val",     val12, 8'h00);
        fetch(4'd11);
        chk("t3.u12_val11",   val12, 8'hAB);

        // Restart mid-load; the word sent with load_start is dropped
        load_start = 1'b1; cyc(); load_start = 1'b0;
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h77;
        cyc();
        load_start = 1'b0; load_valid = 1'b0;
        chk("t4.load_count0", cnt16, 0);
        send(8'h88, 1'b1);
        chk("t4.load_count",  cnt16, 1);
        chk("t4.prog_loaded", ld16,  1);
        fetch(4'd0); chk("t4.mem0", val16, 8'h88);
        fetch(4'd1); chk("t4.mem1", val16, 8'h66);
        fetch(4'd2); chk("t4.mem2", val16, 8'hA2);

        // Out-of-range fetch on the 12-word build; fetch ignored during load
        fetch(4'd13);
        chk("t5.u12_valid", vld12, 1);
        chk("t5.u12_err",   err12, 1);
        chk("t5.u12_val",   val12, 8'h00);
        chk("t5.u16_val",   val16, 8'hAD);
        load_start = 1'b1; cyc(); load_start = 1'b0;
        fetch_req = 1'b1; prog_count = 4'd0;
        cyc();
        chk("t5.load_fetch16", vld16, 0);
        chk("t5.load_fetch12", vld12, 0);
        for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 1'b0);
        fetch_req = 1'b0;

        // Asynchronous reset mid-load
        #1 rst_n = 1'b0;
        #1;
        chk("t6.load_ready",  rdy16, 0);
        chk("t6.prog_loaded", ld16,  0);
        chk("t6.load_count",  cnt16, 0);
        chk("t6.ins_val",     val16, 8'h00);
        chk("t6.ins_valid",   vld16, 0);
        chk("t6.u12_count",   cnt12, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        fetch(4'd2);
        chk("t6.mem2",   val16, 8'h00);
        chk("t6.valid",  vld16, 1);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
